// File: rtl/folded_threshold_eval_if.sv
// Handshake bundle between a vector producer, the folded threshold
// evaluator and the decision consumer. The master side drives vectors
// and the consumer ready; the slave side (the evaluator) returns the
// producer ready and the decision.
interface folded_threshold_eval_if #(
  parameter int N = 9
);
  localparam int CNT_W = $clog2(N + 1);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_vec;
  logic             thr_mode;
  logic [CNT_W-1:0] thr;
  logic             out_valid;
  logic             out_ready;
  logic             y;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_vec, thr_mode, thr, out_ready,
    input  in_ready, out_valid, y, count
  );

  modport slave (
    input  in_valid, in_vec, thr_mode, thr, out_ready,
    output in_ready, out_valid, y, count
  );
endinterface

// File: rtl/folded_threshold_eval.sv
// Folded threshold evaluator: accepts an N-bit vector, counts its ones
// FOLD_W bits per cycle over P = ceil(N/FOLD_W) cycles, then presents the
// popcount and the decision (count >= effective threshold) until the
// consumer takes it. Threshold is either strict majority or programmable.
module folded_threshold_eval #(
  parameter int N      = 9,
  parameter int FOLD_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  folded_threshold_eval_if.slave bus
);

  localparam int CNT_W  = $clog2(N + 1);
  localparam int P      = (N + FOLD_W - 1) / FOLD_W;
  localparam int BEAT_W = (P > 1) ? $clog2(P) : 1;
  // Strict majority: more than half of the N inputs.
  localparam logic [CNT_W-1:0] MAJ_THR = CNT_W'(N / 2 + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Ones in the low FOLD_W bits of the shift register. The result never
  // exceeds FOLD_W <= N, so it fits the count width.
  function automatic logic [CNT_W-1:0] chunk_popcount(input logic [FOLD_W-1:0] chunk);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < FOLD_W; i++) begin
      sum = sum + CNT_W'(chunk[i]);
    end
    return sum;
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_shift;
  logic [CNT_W-1:0] r_acc;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0] r_thr_eff;
  logic [CNT_W-1:0] r_count;
  logic             r_y;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last_beat;
  logic [CNT_W-1:0] w_acc_next;

  // A new vector may enter when idle, or when the pending result leaves
  // in this same cycle; in_valid deliberately plays no part.
  assign w_in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_last_beat = (r_beat == BEAT_W'(P - 1));
  // The shift register zero-fills, so a partial last chunk adds nothing
  // beyond the real vector bits.
  assign w_acc_next  = r_acc + chunk_popcount(r_shift[FOLD_W-1:0]);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.count     = r_count;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection: accept -> accumulate P beats -> hold result.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_last_beat) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_next = w_accept ? S_ACCUM : S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Fold datapath: load on accept, then count and shift one chunk per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_acc     <= '0;
      r_beat    <= '0;
      r_thr_eff <= '0;
    end else if (w_accept) begin
      r_shift   <= bus.in_vec;
      r_acc     <= '0;
      r_beat    <= '0;
      r_thr_eff <= bus.thr_mode ? bus.thr : MAJ_THR;
    end else if (r_state == S_ACCUM) begin
      r_shift   <= r_shift >> FOLD_W;
      r_acc     <= w_acc_next;
      r_beat    <= r_beat + BEAT_W'(1);
    end
  end

  // Result registers: capture on the final beat, hold until transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_y         <= 1'b0;
      r_out_valid <= 1'b0;
    end else if ((r_state == S_ACCUM) && w_last_beat) begin
      r_count     <= w_acc_next;
      r_y         <= (w_acc_next >= r_thr_eff);
      r_out_valid <= 1'b1;
    end else if ((r_state == S_DONE) && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
